// File: rtl/tcb_pkg.sv
// Shared types and default geometry for the trigger capture buffer.
package tcb_pkg;

  localparam int TCB_WIDTH = 8;
  localparam int TCB_DEPTH = 16;
  localparam int TCB_POST  = 8;

  // Capture sequencer states; the numeric codes are exported on the state port.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_READ = 3'd4
  } tcb_state_e;

  // Number of samples that precede the trigger sample in the frozen window.
  function automatic int tcb_pre_samples(input int depth, input int post);
    return depth - post;
  endfunction

endpackage

// File: rtl/trigger_capture_buffer_if.sv
// Read-out stream of the capture buffer: valid/ready handshake with a last marker.
interface trigger_capture_buffer_if #(
  parameter int WIDTH = tcb_pkg::TCB_WIDTH
);

  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_last;

  // Buffer side drives the sample stream.
  modport master (
    output rd_valid,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  // Consumer side accepts the sample stream.
  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/tcb_ram.sv
// Sample store: one write port, one synchronous read port with an output register.
// The array itself is never reset; only the read register is.
module tcb_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register only moves on a read request, so the word holds otherwise.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // Output register with reset so the stream starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trigger_capture_buffer.sv
// Trigger capture buffer: records the probed bus circularly, freezes the window a
// fixed number of samples after the trigger, then streams it out oldest-first.
module trigger_capture_buffer
  import tcb_pkg::*;
#(
  parameter int WIDTH = TCB_WIDTH,
  parameter int DEPTH = TCB_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int POST  = TCB_POST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     arm,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     trig,
  trigger_capture_buffer_if.master rd,
  output logic [2:0]               state
);

  localparam int          PRE      = tcb_pre_samples(DEPTH, POST);
  localparam logic [AW:0] PRE_CNT  = (AW+1)'(PRE);
  localparam logic [AW:0] POST_CNT = (AW+1)'(POST);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  tcb_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  // One counter serves each phase in turn: pre-fill writes, post writes, transfers.
  logic [AW:0] cnt_q, cnt_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_last_q, rd_last_d;

  logic          enter_read;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          xfer;

  assign xfer = rd_valid_q && rd.rd_ready;

  // Next-state, pointer and counter logic for the capture sequence.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    enter_read = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = rd_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          wr_ptr_d = '0;
          cnt_d    = '0;
          state_d  = (PRE == 0) ? ST_WAIT : ST_FILL;
        end
      end

      // Pre-trigger fill; triggers are ignored until the window is full.
      ST_FILL: begin
        if (ena) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_d == PRE_CNT) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end

      // Keep recording; an enabled trigger sample is post sample number one.
      ST_WAIT: begin
        if (ena) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (trig) begin
            cnt_d = (AW+1)'(1);
            if (POST == 1) begin
              enter_read = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
      end

      ST_POST: begin
        if (ena) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_d == POST_CNT) begin
            enter_read = 1'b1;
          end
        end
      end

      // Stream out; each transfer prefetches the following word.
      ST_READ: begin
        if (xfer) begin
          if (rd_last_q) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            cnt_d      = '0;
            state_d    = ST_IDLE;
          end else begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            cnt_d     = cnt_q + 1'b1;
            rd_last_d = (cnt_d == LAST_CNT);
            rd_en     = 1'b1;
            rd_addr   = rd_ptr_d;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The slot after the final write holds the oldest sample; it is never the
    // slot being written on this edge, so its read is hazard-free.
    if (enter_read) begin
      state_d    = ST_READ;
      rd_ptr_d   = wr_ptr_d;
      cnt_d      = '0;
      rd_valid_d = 1'b1;
      rd_last_d  = 1'b0;
      rd_en      = 1'b1;
      rd_addr    = wr_ptr_d;
    end
  end

  // State, pointers, counter and registered stream flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  tcb_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (sample_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd.rd_data)
  );

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign state       = state_q;

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Bench for trigger_capture_buffer: two builds (POST=8 and POST=16) share one
// counting sample bus; expected windows are queued at trigger time and popped
// on each read transfer.
module tb_trigger_capture_buffer;

  localparam int DEPTH  = 16;
  localparam int POST_A = 8;
  localparam int POST_B = 16;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] sample_in;
  logic       arm_a, trig_a, arm_b, trig_b;
  logic       rd_ready_a;
  logic [2:0] state_a, state_b;

  trigger_capture_buffer_if #(.WIDTH(8)) rd_a ();
  trigger_capture_buffer_if #(.WIDTH(8)) rd_b ();

  assign rd_a.rd_ready = rd_ready_a;
  assign rd_b.rd_ready = 1'b1;

  trigger_capture_buffer #(.WIDTH(8), .DEPTH(DEPTH), .POST(POST_A)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .arm(arm_a), .sample_in(sample_in),
    .trig(trig_a), .rd(rd_a), .state(state_a)
  );

  trigger_capture_buffer #(.WIDTH(8), .DEPTH(DEPTH), .POST(POST_B)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .arm(arm_b), .sample_in(sample_in),
    .trig(trig_b), .rd(rd_b), .state(state_b)
  );

  int   vectors;
  int   miscompares;
  int   cnt;
  bit   toggle_ready;
  exp_t qa[$];
  exp_t qb[$];
  int   xfer_a, xfer_b;
  bit   held_a;
  logic [7:0] held_data_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the bus counts only on enabled cycles, pulses self-clear.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ena) cnt = cnt + 1;
    sample_in  = 8'(cnt);
    arm_a      = 1'b0;
    trig_a     = 1'b0;
    arm_b      = 1'b0;
    trig_b     = 1'b0;
    rd_ready_a = toggle_ready ? ~rd_ready_a : 1'b1;
  endtask

  task automatic restart_count();
    cnt       = 0;
    sample_in = 8'd0;
  endtask

  task automatic run_to(input int v);
    for (int i = 0; i < 500 && cnt != v; i++) tick();
    if (cnt != v) chk("run_to", cnt, v);
  endtask

  // The window is the DEPTH enabled samples ending POST-1 after the trigger.
  task automatic push_window(input bit sel, input int t);
    exp_t e;
    int   post;
    post = sel ? POST_B : POST_A;
    for (int i = 0; i < DEPTH; i++) begin
      e.data = 8'(t + post - DEPTH + i);
      e.last = (i == DEPTH - 1);
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
    end
  endtask

  task automatic wait_state(input bit sel, input logic [2:0] s);
    for (int i = 0; i < 300 && (sel ? state_b : state_a) != s; i++) tick();
    chk(sel ? "b_wait_state" : "a_wait_state", sel ? state_b : state_a, s);
  endtask

  task automatic wait_done(input bit sel);
    for (int i = 0; i < 400; i++) begin
      if ((sel ? state_b : state_a) == 3'd0 && (sel ? qb.size() : qa.size()) == 0) break;
      tick();
    end
    chk(sel ? "b_done_state" : "a_done_state", sel ? state_b : state_a, 3'd0);
    chk(sel ? "b_queue_empty" : "a_queue_empty", sel ? qb.size() : qa.size(), 0);
    chk(sel ? "b_xfers" : "a_xfers", sel ? xfer_b : xfer_a, DEPTH);
    chk(sel ? "b_valid_off" : "a_valid_off", sel ? rd_b.rd_valid : rd_a.rd_valid, 1'b0);
    if (sel) xfer_b = 0;
    else     xfer_a = 0;
  endtask

  // Monitor A: scoreboard pop on each transfer plus hold checks under back-pressure.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      held_a = 1'b0;
    end else begin
      if (held_a) begin
        chk("a_hold_valid", rd_a.rd_valid, 1'b1);
        chk("a_hold_data", rd_a.rd_data, held_data_a);
      end
      if (rd_a.rd_valid && rd_a.rd_ready) begin
        $display("a xfer %0d data=%0d last=%0b", xfer_a, rd_a.rd_data, rd_a.rd_last);
        if (qa.size() == 0) begin
          chk("a_unexpected_xfer", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_data", rd_a.rd_data, e.data);
          chk("a_last", rd_a.rd_last, e.last);
        end
        xfer_a++;
      end
      held_a      = rd_a.rd_valid && !rd_a.rd_ready;
      held_data_a = rd_a.rd_data;
    end
  end

  // Monitor B: consumer always ready.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && rd_b.rd_valid) begin
      $display("b xfer %0d data=%0d last=%0b", xfer_b, rd_b.rd_data, rd_b.rd_last);
      if (qb.size() == 0) begin
        chk("b_unexpected_xfer", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_data", rd_b.rd_data, e.data);
        chk("b_last", rd_b.rd_last, e.last);
      end
      xfer_b++;
    end
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    xfer_a       = 0;
    xfer_b       = 0;
    held_a       = 1'b0;
    toggle_ready = 1'b0;
    rst          = 1'b1;
    ena          = 1'b0;
    arm_a        = 1'b0;
    trig_a       = 1'b0;
    arm_b        = 1'b0;
    trig_b       = 1'b0;
    rd_ready_a   = 1'b1;
    restart_count();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state_a", state_a, 3'd0);
    chk("rst_valid_a", rd_a.rd_valid, 1'b0);
    chk("rst_data_a", rd_a.rd_data, 8'd0);
    chk("rst_last_a", rd_a.rd_last, 1'b0);
    chk("rst_state_b", state_b, 3'd0);
    chk("rst_valid_b", rd_b.rd_valid, 1'b0);
    rst = 1'b0;
    ena = 1'b1;
    tick();

    // 1: trigger during fill ignored, trigger at 20 gives 12..27.
    restart_count();
    arm_a = 1'b1;
    tick();
    chk("t1_fill", state_a, 3'd1);
    run_to(3);
    trig_a = 1'b1;
    tick();
    chk("t1_fill_trig_ignored", state_a, 3'd1);
    run_to(20);
    chk("t1_wait", state_a, 3'd2);
    trig_a = 1'b1;
    push_window(1'b0, 20);
    tick();
    chk("t1_post", state_a, 3'd3);
    wait_done(1'b0);

    // 2: same capture with the consumer stalling every other cycle.
    toggle_ready = 1'b1;
    restart_count();
    arm_a = 1'b1;
    tick();
    run_to(20);
    trig_a = 1'b1;
    push_window(1'b0, 20);
    tick();
    wait_done(1'b0);
    toggle_ready = 1'b0;
    tick();

    // 3: disabled trigger in WAIT ignored; pause for 5 cycles in POST.
    restart_count();
    arm_a = 1'b1;
    tick();
    run_to(10);
    ena    = 1'b0;
    trig_a = 1'b1;
    tick();
    chk("t3_trig_no_ena", state_a, 3'd2);
    ena = 1'b1;
    run_to(14);
    trig_a = 1'b1;
    push_window(1'b0, 14);
    tick();
    run_to(17);
    ena = 1'b0;
    repeat (5) tick();
    chk("t3_paused_post", state_a, 3'd3);
    chk("t3_count_frozen", sample_in, 8'd17);
    ena = 1'b1;
    wait_done(1'b0);

    // 4: reset in the middle of POST, then a clean capture.
    restart_count();
    arm_a = 1'b1;
    tick();
    run_to(12);
    trig_a = 1'b1;
    tick();
    run_to(15);
    chk("t4_mid_post", state_a, 3'd3);
    rst = 1'b1;
    qa.delete();
    tick();
    chk("t4_rst_state", state_a, 3'd0);
    chk("t4_rst_valid", rd_a.rd_valid, 1'b0);
    rst    = 1'b0;
    xfer_a = 0;
    tick();
    restart_count();
    arm_a = 1'b1;
    tick();
    run_to(11);
    trig_a = 1'b1;
    push_window(1'b0, 11);
    tick();
    wait_done(1'b0);

    // 5: POST=DEPTH build, arm then trigger on the very next sample.
    restart_count();
    run_to(4);
    arm_b = 1'b1;
    tick();
    chk("t5_wait_direct", state_b, 3'd2);
    trig_b = 1'b1;
    push_window(1'b1, 5);
    tick();
    wait_done(1'b1);

    // 6: arm and trig during READ have no effect.
    toggle_ready = 1'b1;
    restart_count();
    arm_a = 1'b1;
    tick();
    run_to(30);
    trig_a = 1'b1;
    push_window(1'b0, 30);
    tick();
    wait_state(1'b0, 3'd4);
    arm_a  = 1'b1;
    trig_a = 1'b1;
    tick();
    repeat (3) tick();
    arm_a  = 1'b1;
    trig_a = 1'b1;
    tick();
    chk("t6_still_read", state_a, 3'd4);
    wait_done(1'b0);
    toggle_ready = 1'b0;
    repeat (3) tick();
    chk("t6_stays_idle", state_a, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
